encoder: RTL and testbench

//   Registered 2-input one's-count encoder (half-adder form): encodes how many of

---
 rtl/encoder_if.sv | 23 ++
 rtl/encoder.sv | 48 ++++
 tb/tb_encoder.sv | 128 ++++++++++++
 3 files changed

// File: rtl/encoder_if.sv
// Sample/result bundle for the registered half-adder encoder.
// The master drives the operands and enable; the slave returns the encoded result.
interface encoder_if #(
  parameter int CNT_W = 8
) ();
  logic             en;
  logic             a;
  logic             b;
  logic             S;
  logic             Cout;
  logic             out_valid;
  logic [CNT_W-1:0] carry_cnt;

  modport master (
    output en, a, b,
    input  S, Cout, out_valid, carry_cnt
  );

  modport slave (
    input  en, a, b,
    output S, Cout, out_valid, carry_cnt
  );
endinterface

// File: rtl/encoder.sv
// Registered 2-input one's-count encoder: {Cout,S} = a + b with one cycle of latency.
// It also keeps a saturating count of accepted samples that produced a carry.
module encoder #(
  parameter int CNT_W = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  encoder_if.slave  bus
);

  logic             r_sum;
  logic             r_carry;
  logic             r_outValid;
  logic [CNT_W-1:0] r_carryCnt;

  logic             w_sum;
  logic             w_carry;
  logic             w_cntSat;

  assign w_sum    = bus.a ^ bus.b;
  assign w_carry  = bus.a & bus.b;
  assign w_cntSat = &r_carryCnt;

  // S/Cout hold through idle cycles; only out_valid drops when en is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sum      <= 1'b0;
      r_carry    <= 1'b0;
      r_outValid <= 1'b0;
      r_carryCnt <= '0;
    end else begin
      r_outValid <= bus.en;
      if (bus.en) begin
        r_sum   <= w_sum;
        r_carry <= w_carry;
        if (w_carry && !w_cntSat) begin
          r_carryCnt <= r_carryCnt + CNT_W'(1);
        end
      end
    end
  end

  assign bus.S         = r_sum;
  assign bus.Cout      = r_carry;
  assign bus.out_valid = r_outValid;
  assign bus.carry_cnt = r_carryCnt;

endmodule

// File: tb/tb_encoder.sv
// Scoreboard bench for encoder: directed vectors carry hand-computed results,
// which are queued at the sampling edge and checked by an independent monitor.
module tb_encoder;

  localparam int CNT_W = 2;

  typedef struct {
    string            name;
    logic             rstN;
    logic             en;
    logic             a;
    logic             b;
    logic             expS;
    logic             expCout;
    logic             expValid;
    logic [CNT_W-1:0] expCnt;
  } vec_t;

  logic clk;
  logic rst_n;

  encoder_if #(.CNT_W(CNT_W)) bus ();

  encoder #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  vec_t vecs[$];
  vec_t scoreboard[$];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic addVec(input string name, input logic rstN, input logic en,
                        input logic a, input logic b, input logic s,
                        input logic cout, input logic valid,
                        input logic [CNT_W-1:0] cnt);
    vec_t v;
    v.name = name; v.rstN = rstN; v.en = en; v.a = a; v.b = b;
    v.expS = s; v.expCout = cout; v.expValid = valid; v.expCnt = cnt;
    vecs.push_back(v);
  endtask

  // Drive one vector, let the clock edge take it, then queue its expected result.
  task automatic applyStimulus(input vec_t v);
    rst_n  = v.rstN;
    bus.en = v.en;
    bus.a  = v.a;
    bus.b  = v.b;
    @(posedge clk);
    scoreboard.push_back(v);
    @(negedge clk);
  endtask

  task automatic checkField(input string name, input string field,
                            input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s.%s actual=%0d expected=%0d", name, field, actual, expected);
    end
  endtask

  task automatic checkOutput(input vec_t v);
    checkField(v.name, "S", int'(bus.S), int'(v.expS));
    checkField(v.name, "Cout", int'(bus.Cout), int'(v.expCout));
    checkField(v.name, "out_valid", int'(bus.out_valid), int'(v.expValid));
    checkField(v.name, "carry_cnt", int'(bus.carry_cnt), int'(v.expCnt));
  endtask

  // Monitor: samples on the falling edge, away from the edge that updates the DUT.
  always @(negedge clk) begin
    if (scoreboard.size() > 0) begin
      vec_t e;
      e = scoreboard.pop_front();
      checkOutput(e);
    end
  end

  initial begin
    rst_n  = 1'b0;
    bus.en = 1'b0;
    bus.a  = 1'b0;
    bus.b  = 1'b0;

    //     name          rst en a  b   S  C  V  cnt
    addVec("reset0",     0, 1, 1, 1,  0, 0, 0, 2'd0);
    addVec("reset1",     0, 1, 1, 1,  0, 0, 0, 2'd0);
    addVec("enc00",      1, 1, 0, 0,  0, 0, 1, 2'd0);
    addVec("enc01",      1, 1, 0, 1,  1, 0, 1, 2'd0);
    addVec("enc10",      1, 1, 1, 0,  1, 0, 1, 2'd0);
    addVec("enc11",      1, 1, 1, 1,  0, 1, 1, 2'd1);
    addVec("idle0",      1, 0, 0, 0,  0, 1, 0, 2'd1);
    addVec("idle1",      1, 0, 0, 0,  0, 1, 0, 2'd1);
    addVec("idle2",      1, 0, 0, 0,  0, 1, 0, 2'd1);
    addVec("satReset",   0, 1, 1, 1,  0, 0, 0, 2'd0);
    addVec("sat1",       1, 1, 1, 1,  0, 1, 1, 2'd1);
    addVec("sat2",       1, 1, 1, 1,  0, 1, 1, 2'd2);
    addVec("sat3",       1, 1, 1, 1,  0, 1, 1, 2'd3);
    addVec("sat4",       1, 1, 1, 1,  0, 1, 1, 2'd3);
    addVec("sat5",       1, 1, 1, 1,  0, 1, 1, 2'd3);
    addVec("square0",    1, 1, 0, 0,  0, 0, 1, 2'd3);
    addVec("square1",    1, 1, 0, 1,  1, 0, 1, 2'd3);
    addVec("square2",    1, 1, 1, 0,  1, 0, 1, 2'd3);
    addVec("square3",    1, 1, 1, 1,  0, 1, 1, 2'd3);
    addVec("midReset",   0, 1, 1, 1,  0, 0, 0, 2'd0);
    addVec("resume11",   1, 1, 1, 1,  0, 1, 1, 2'd1);
    addVec("resume10",   1, 1, 1, 0,  1, 0, 1, 2'd1);
    addVec("resumeIdle", 1, 0, 0, 1,  1, 0, 0, 2'd1);

    foreach (vecs[i]) applyStimulus(vecs[i]);

    for (int n = 0; n < 10 && scoreboard.size() > 0; n++) @(negedge clk);
    if (scoreboard.size() > 0) begin
      errors++;
      $display("[TB] FAIL drain pending=%0d required=0", scoreboard.size());
    end

    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
